// File: rtl/rally_controller_if.sv
// rtl/rally_controller_if.sv - frame-strobe, button, miss and status bundle for rally_controller
interface rally_controller_if;
    logic       i_vsync_pulse;
    logic       i_left_button;
    logic       i_right_button;
    logic       i_left_miss;
    logic       i_right_miss;
    logic       o_left_player_start;
    logic       o_right_player_start;
    logic       o_ball_in_game;
    logic [3:0] o_left_score;
    logic [3:0] o_right_score;
    logic       o_game_over;
    logic       o_winner;

    modport master (
        output i_vsync_pulse, i_left_button, i_right_button, i_left_miss, i_right_miss,
        input  o_left_player_start, o_right_player_start, o_ball_in_game,
               o_left_score, o_right_score, o_game_over, o_winner
    );

    modport slave (
        input  i_vsync_pulse, i_left_button, i_right_button, i_left_miss, i_right_miss,
        output o_left_player_start, o_right_player_start, o_ball_in_game,
               o_left_score, o_right_score, o_game_over, o_winner
    );
endinterface

// File: rtl/rally_controller.sv
// rtl/rally_controller.sv - pong serve/rally/point/game-over sequencer with scoring
module rally_controller #(
    parameter int WIN_SCORE          = 9,
    parameter int SERVE_DELAY_FRAMES = 60
) (
    input  logic               i_clock,
    input  logic               i_reset,
    rally_controller_if.slave  bus
);
    typedef enum logic [1:0] {SERVE_WAIT, RALLY, POINT, GAME_OVER} state_t;

    localparam logic [4:0] WIN_L   = 5'(WIN_SCORE);
    localparam logic [8:0] DELAY_L = 9'(SERVE_DELAY_FRAMES);

    state_t     state_q, state_d;
    logic       server_q, server_d;
    logic [3:0] left_score_q, left_score_d;
    logic [3:0] right_score_q, right_score_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       left_prev_q, left_prev_d;
    logic       right_prev_q, right_prev_d;
    logic       winner_q, winner_d;
    logic       left_start_q, left_start_d;
    logic       right_start_q, right_start_d;
    logic       in_game_q, in_game_d;
    logic       game_over_q, game_over_d;

    logic       left_press, right_press, server_press;
    logic       left_wins, right_wins;

    assign left_press   = bus.i_left_button & ~left_prev_q;
    assign right_press  = bus.i_right_button & ~right_prev_q;
    assign server_press = server_q ? right_press : left_press;
    assign left_wins    = ({1'b0, left_score_q} + 5'd1) == WIN_L;
    assign right_wins   = ({1'b0, right_score_q} + 5'd1) == WIN_L;

    always_comb begin
        state_d       = state_q;
        server_d      = server_q;
        left_score_d  = left_score_q;
        right_score_d = right_score_q;
        frame_cnt_d   = frame_cnt_q;
        left_prev_d   = left_prev_q;
        right_prev_d  = right_prev_q;
        winner_d      = winner_q;

        if (bus.i_vsync_pulse) begin
            left_prev_d  = bus.i_left_button;
            right_prev_d = bus.i_right_button;
            unique case (state_q)
                SERVE_WAIT: begin
                    // Launch needs two full frames of the ball parked on the paddle.
                    if (server_press && frame_cnt_q >= 8'd2) begin
                        state_d     = RALLY;
                        frame_cnt_d = 8'd0;
                    end else if (frame_cnt_q < 8'd2) begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                RALLY: begin
                    if (bus.i_left_miss && bus.i_right_miss) begin
                        state_d     = POINT;
                        frame_cnt_d = 8'd0;
                    end else if (bus.i_left_miss) begin
                        right_score_d = right_score_q + 4'd1;
                        server_d      = 1'b0;
                        frame_cnt_d   = 8'd0;
                        if (right_wins) begin
                            state_d  = GAME_OVER;
                            winner_d = 1'b1;
                        end else begin
                            state_d  = POINT;
                        end
                    end else if (bus.i_right_miss) begin
                        left_score_d = left_score_q + 4'd1;
                        server_d     = 1'b1;
                        frame_cnt_d  = 8'd0;
                        if (left_wins) begin
                            state_d  = GAME_OVER;
                            winner_d = 1'b0;
                        end else begin
                            state_d  = POINT;
                        end
                    end
                end
                POINT: begin
                    if (({1'b0, frame_cnt_q} + 9'd1) == DELAY_L) begin
                        state_d     = SERVE_WAIT;
                        frame_cnt_d = 8'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                GAME_OVER: begin
                    if (left_press || right_press) begin
                        state_d       = SERVE_WAIT;
                        left_score_d  = 4'd0;
                        right_score_d = 4'd0;
                        server_d      = ~winner_q;
                        frame_cnt_d   = 8'd0;
                    end
                end
                default: state_d = SERVE_WAIT;
            endcase
        end

        // Outputs are decoded from next state so they land on the same edge as it.
        left_start_d  = (state_d == SERVE_WAIT) && !server_d;
        right_start_d = (state_d == SERVE_WAIT) && server_d;
        in_game_d     = (state_d == RALLY);
        game_over_d   = (state_d == GAME_OVER);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= SERVE_WAIT;
            server_q      <= 1'b0;
            left_score_q  <= 4'd0;
            right_score_q <= 4'd0;
            frame_cnt_q   <= 8'd0;
            left_prev_q   <= 1'b1;
            right_prev_q  <= 1'b1;
            winner_q      <= 1'b0;
            left_start_q  <= 1'b1;
            right_start_q <= 1'b0;
            in_game_q     <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            server_q      <= server_d;
            left_score_q  <= left_score_d;
            right_score_q <= right_score_d;
            frame_cnt_q   <= frame_cnt_d;
            left_prev_q   <= left_prev_d;
            right_prev_q  <= right_prev_d;
            winner_q      <= winner_d;
            left_start_q  <= left_start_d;
            right_start_q <= right_start_d;
            in_game_q     <= in_game_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.o_left_player_start  = left_start_q;
    assign bus.o_right_player_start = right_start_q;
    assign bus.o_ball_in_game       = in_game_q;
    assign bus.o_left_score         = left_score_q;
    assign bus.o_right_score        = right_score_q;
    assign bus.o_game_over          = game_over_q;
    assign bus.o_winner             = winner_q;
endmodule

// File: tb/tb_rally_controller.sv
// tb/tb_rally_controller.sv - randomized and directed checks of rally_controller against a frame-level model
module tb_rally_controller;
    localparam int W = 3;
    localparam int D = 4;

    logic i_clock = 1'b0;
    logic i_reset = 1'b1;
    rally_controller_if bus ();

    rally_controller #(.WIN_SCORE(W), .SERVE_DELAY_FRAMES(D)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clock = ~i_clock;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    // Frame-level model: scores, who serves, and how the current frame is spent.
    int m_ls, m_rs, m_serve, m_point;
    bit m_srv, m_over, m_win, m_rally, m_lprev, m_rprev;

    task automatic model_reset();
        m_ls = 0; m_rs = 0; m_serve = 0; m_point = 0;
        m_srv = 0; m_over = 0; m_win = 0; m_rally = 0;
        m_lprev = 1; m_rprev = 1;
    endtask

    task automatic model_vsync(input bit lb, input bit rb, input bit lm, input bit rm);
        bit lp, rp;
        lp = lb && !m_lprev;
        rp = rb && !m_rprev;
        m_lprev = lb;
        m_rprev = rb;
        if (m_over) begin
            if (lp || rp) begin
                m_ls = 0; m_rs = 0; m_srv = !m_win; m_over = 0; m_serve = 0;
            end
        end else if (m_rally) begin
            if (lm || rm) m_rally = 0;
            if (lm && rm) m_point = D;
            else if (lm) begin
                m_rs++; m_srv = 0;
                if (m_rs == W) begin m_over = 1; m_win = 1; end else m_point = D;
            end else if (rm) begin
                m_ls++; m_srv = 1;
                if (m_ls == W) begin m_over = 1; m_win = 0; end else m_point = D;
            end
        end else if (m_point > 0) begin
            m_point--;
            if (m_point == 0) m_serve = 0;
        end else begin
            if ((m_srv ? rp : lp) && m_serve >= 2) m_rally = 1;
            else if (m_serve < 2) m_serve++;
        end
    endtask

    function automatic logic [12:0] exp_vec();
        bit serving;
        serving = !m_over && !m_rally && m_point == 0;
        return {serving && !m_srv, serving && m_srv, m_rally, 4'(m_ls), 4'(m_rs),
                m_over, m_over && m_win};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {bus.o_left_player_start, bus.o_right_player_start, bus.o_ball_in_game,
                bus.o_left_score, bus.o_right_score, bus.o_game_over,
                bus.o_game_over && bus.o_winner};
    endfunction

    always @(posedge i_clock) begin
        #2;
        if (chk_en) begin
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL cycle_compare t=%0t got=%b expected=%b", $time, dut_vec(), exp_vec());
            end
            vectors++;
            if (bus.o_left_player_start && bus.o_right_player_start) begin
                errors++;
                $display("FAIL start_exclusive t=%0t got=11 expected=not both", $time);
            end
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, expv);
        end
    endtask

    task automatic frame(input bit lb, input bit rb, input bit lm, input bit rm, input int gap);
        @(negedge i_clock);
        bus.i_vsync_pulse  = 1'b1;
        bus.i_left_button  = lb;
        bus.i_right_button = rb;
        bus.i_left_miss    = lm;
        bus.i_right_miss   = rm;
        model_vsync(lb, rb, lm, rm);
        for (int k = 0; k <= gap; k++) begin
            @(negedge i_clock);
            bus.i_vsync_pulse = 1'b0;
            bus.i_left_miss   = 1'($urandom_range(0, 1));
            bus.i_right_miss  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle_frames(input int n);
        for (int k = 0; k < n; k++) frame(0, 0, 0, 0, 1);
    endtask

    initial begin
        bus.i_vsync_pulse  = 1'b0;
        bus.i_left_button  = 1'b0;
        bus.i_right_button = 1'b0;
        bus.i_left_miss    = 1'b0;
        bus.i_right_miss   = 1'b0;
        model_reset();
        repeat (2) @(negedge i_clock);
        chk("reset_left_start", int'(bus.o_left_player_start), 1);
        chk("reset_right_start", int'(bus.o_right_player_start), 0);
        chk("reset_in_game", int'(bus.o_ball_in_game), 0);
        chk("reset_game_over", int'(bus.o_game_over), 0);
        chk("reset_winner", int'(bus.o_winner), 0);
        chk("reset_scores", int'({bus.o_left_score, bus.o_right_score}), 0);
        i_reset = 1'b0;
        chk_en  = 1'b1;

        // Early press ignored, launch on third vsync.
        frame(1, 0, 0, 0, 1);
        chk("early_press_in_game", int'(bus.o_ball_in_game), 0);
        frame(0, 0, 0, 0, 1);
        frame(1, 0, 0, 0, 1);
        chk("launch_in_game", int'(bus.o_ball_in_game), 1);
        chk("launch_left_start", int'(bus.o_left_player_start), 0);

        // Left miss: right scores, POINT for exactly D vsyncs.
        frame(0, 0, 1, 0, 1);
        chk("lmiss_right_score", int'(bus.o_right_score), 1);
        chk("lmiss_in_game", int'(bus.o_ball_in_game), 0);
        for (int k = 0; k < D - 1; k++) begin
            frame(0, 0, 0, 0, 1);
            chk("point_hold_left_start", int'(bus.o_left_player_start), 0);
        end
        frame(0, 0, 0, 0, 1);
        chk("point_end_left_start", int'(bus.o_left_player_start), 1);

        // Simultaneous misses.
        idle_frames(2);
        frame(1, 0, 0, 0, 1);
        chk("relaunch_in_game", int'(bus.o_ball_in_game), 1);
        frame(0, 0, 1, 1, 1);
        chk("both_miss_scores", int'({bus.o_left_score, bus.o_right_score}), 1);
        chk("both_miss_in_game", int'(bus.o_ball_in_game), 0);
        idle_frames(D);
        chk("both_miss_server_left", int'(bus.o_left_player_start), 1);
        chk("both_miss_right_start", int'(bus.o_right_player_start), 0);

        // Non-server button does not launch.
        idle_frames(2);
        frame(0, 1, 0, 0, 1);
        chk("wrong_button_in_game", int'(bus.o_ball_in_game), 0);
        frame(0, 0, 0, 0, 1);

        // Right wins the game.
        frame(1, 0, 0, 0, 1);
        frame(0, 0, 1, 0, 1);
        chk("second_point_right", int'(bus.o_right_score), 2);
        idle_frames(D + 2);
        frame(1, 0, 0, 0, 1);
        frame(0, 1, 1, 0, 1);
        chk("win_game_over", int'(bus.o_game_over), 1);
        chk("win_winner", int'(bus.o_winner), 1);
        chk("win_right_score", int'(bus.o_right_score), 3);
        frame(0, 1, 1, 1, 1);
        frame(0, 1, 1, 0, 1);
        chk("frozen_right_score", int'(bus.o_right_score), 3);
        chk("frozen_game_over", int'(bus.o_game_over), 1);
        frame(0, 0, 0, 0, 1);
        frame(0, 1, 0, 0, 1);
        chk("restart_game_over", int'(bus.o_game_over), 0);
        chk("restart_scores", int'({bus.o_left_score, bus.o_right_score}), 0);
        chk("restart_left_start", int'(bus.o_left_player_start), 1);

        // Reset mid-rally with a right miss on the same vsync.
        idle_frames(2);
        frame(1, 0, 0, 0, 1);
        frame(0, 0, 0, 0, 1);
        chk("pre_abort_in_game", int'(bus.o_ball_in_game), 1);
        @(negedge i_clock);
        bus.i_vsync_pulse = 1'b1;
        bus.i_right_miss  = 1'b1;
        #2;
        i_reset = 1'b1;
        model_reset();
        #1;
        chk("abort_left_start", int'(bus.o_left_player_start), 1);
        chk("abort_in_game", int'(bus.o_ball_in_game), 0);
        chk("abort_left_score", int'(bus.o_left_score), 0);
        @(negedge i_clock);
        bus.i_vsync_pulse = 1'b0;
        bus.i_right_miss  = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b0;

        // Randomized play against the model.
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                @(negedge i_clock);
                bus.i_left_button  = 1'($urandom_range(0, 1));
                bus.i_right_button = 1'($urandom_range(0, 1));
                i_reset = 1'b1;
                model_reset();
                @(negedge i_clock);
                i_reset = 1'b0;
            end else begin
                frame(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                      int'($urandom_range(0, 3)));
            end
        end

        @(negedge i_clock);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/rally_controller.md
RALLY_CONTROLLER -- requirements
Module: rally_controller

Interface
REQ-001 Parameter WIN_SCORE, default 9, points that end a game; legal range 1..15.
REQ-002 Parameter SERVE_DELAY_FRAMES, default 60, frames the POINT pause lasts; legal range 1..255.
REQ-003 i_clock  in  1  system clock.
REQ-004 i_reset  in  1  asynchronous, active-high reset.
REQ-005 i_vsync_pulse  in  1  one-cycle frame strobe; all state/score updates qualified by it.
REQ-006 i_left_button, i_right_button  in  1 each  serve/restart buttons; synchronized, debounced levels.
REQ-007 i_left_miss, i_right_miss  in  1 each  ball passed left/right wall (levels from ball datapath).
REQ-008 o_left_player_start, o_right_player_start  out  1 each  hold ball on that player's paddle and arm serve direction.
REQ-009 o_ball_in_game  out  1  ball moving freely.
REQ-010 o_left_score, o_right_score  out  4 each  current points.
REQ-011 o_game_over  out  1  a player reached WIN_SCORE.
REQ-012 o_winner  out  1  0 = left, 1 = right; valid only while o_game_over=1.

Function
REQ-013 States: SERVE_WAIT, RALLY, POINT, GAME_OVER; transitions only on cycles with i_vsync_pulse=1.
REQ-014 All outputs registered; they change only on the cycle after an accepted i_vsync_pulse and stay stable until the next one.
REQ-015 Server register (0 left, 1 right) selects which start output is driven; both start outputs are never 1 simultaneously.
REQ-016 Press detection: per button, previous level sampled at each vsync; press = current 1 and previous 0 at that vsync; held buttons never re-trigger.
REQ-017 SERVE_WAIT: o_ball_in_game=0; server's start output=1; frame counter increments per vsync, saturating at 2.
REQ-018 SERVE_WAIT -> RALLY on server-button press when frame counter >= 2 (at least two full frames with start asserted); the non-server button is ignored.
REQ-019 RALLY: o_ball_in_game=1; both start outputs 0.
REQ-020 RALLY, i_left_miss=1 only: o_right_score+1, server:=left, -> POINT.
REQ-021 RALLY, i_right_miss=1 only: o_left_score+1, server:=right, -> POINT.
REQ-022 RALLY, both misses at same vsync: no score change, server unchanged, -> POINT.
REQ-023 Button presses during RALLY, POINT and the launching vsync are ignored.
REQ-024 POINT: o_ball_in_game=0, start outputs 0; frame counter cleared on entry, counts vsyncs; after SERVE_DELAY_FRAMES vsyncs -> SERVE_WAIT (frame counter cleared).
REQ-025 Score update and game-over check at the same vsync: if the incremented score equals WIN_SCORE -> GAME_OVER instead of POINT; o_winner = scorer.
REQ-026 Scores never exceed WIN_SCORE; no wrap-around.
REQ-027 GAME_OVER: o_game_over=1, o_ball_in_game=0, start outputs 0, scores frozen; press on either button -> both scores 0, server := loser, o_game_over=0, -> SERVE_WAIT.
REQ-028 Miss inputs are ignored outside RALLY.

Reset
REQ-029 On i_reset: state SERVE_WAIT, server=left, scores 0, frame counter 0, button history 1 (a button held through reset is not a press).
REQ-030 Outputs during/after reset: o_left_player_start=1, o_right_player_start=0, o_ball_in_game=0, o_game_over=0, o_winner=0, scores 0.
REQ-031 Reset asserted mid-RALLY or mid-POINT aborts immediately; no score update is committed.

Verification (WIN_SCORE=3, SERVE_DELAY_FRAMES=4)
REQ-032 Reset, left button pressed at vsync 1 -> ignored (counter<2); press at vsync 3 -> o_ball_in_game=1, o_left_player_start=0 after that vsync.
REQ-033 In RALLY assert i_left_miss -> o_right_score=1, POINT for exactly 4 vsyncs, then SERVE_WAIT with o_left_player_start=1.
REQ-034 Both misses on the same vsync -> scores unchanged, POINT entered, same server afterwards.
REQ-035 Right scores three points -> o_game_over=1, o_winner=1, o_right_score=3; further misses and held buttons cause no change; fresh right press -> scores 0, o_left_player_start=1.
REQ-036 Reset asserted mid-RALLY with i_right_miss=1 -> outputs equal REQ-030 values, o_left_score=0.
REQ-037 Right button pressed in SERVE_WAIT with server=left -> no launch; start outputs never both 1 on any cycle.
